// File: rtl/jetpack_pkg.sv
// Shared types and helpers for the obstacle scheduler and its slots.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package jetpack_pkg;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } game_state_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } slot_state_t;

    typedef logic [1:0] obs_type_t;
    typedef logic [1:0] obs_pos_t;

    localparam obs_pos_t TOP = 2'd0;
    localparam obs_pos_t MID = 2'd1;
    localparam obs_pos_t BOT = 2'd2;

    // Only three lanes exist; the spare random code lands in the middle lane.
    function automatic obs_pos_t lane_fix(input logic [1:0] raw);
        return (raw == 2'b11) ? MID : obs_pos_t'(raw);
    endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: spawns, scrolls left by speed per tick, retires past x=0, flickers.
// Latency: outputs registered, new values visible the cycle after tick; retire is combinational on the tick edge.
// Backpressure: none; tick and spawn are one-cycle commands that are always accepted.
//
// Ports: clk, reset_n (async active-low); tick (frame update), speed (px/frame),
//        spawn/new_type/new_pos (load a new obstacle, only issued while idle);
//        x, obs_type, obs_pos, flick, active (slot state), retire (pulse on the retiring tick edge).
module obstacle_slot
    import jetpack_pkg::*;
#(
    parameter int SPAWN_X      = 740,
    parameter int PARK_X       = 1000,
    parameter int FLICK_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic [2:0] speed,
    input  logic       spawn,
    input  logic [1:0] new_type,
    input  logic [1:0] new_pos,
    output logic [9:0] x,
    output logic [1:0] obs_type,
    output logic [1:0] obs_pos,
    output logic       flick,
    output logic       active,
    output logic       retire
);

    localparam int            FW         = $clog2(FLICK_FRAMES + 1);
    localparam logic [FW-1:0] FLICK_LAST = FW'(FLICK_FRAMES - 1);

    slot_state_t   st;
    logic [FW-1:0] fcnt;

    assign active = (st == ACTIVE);
    // An obstacle that cannot make a full step this frame leaves the screen.
    assign retire = tick && active && (x < {7'd0, speed});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= IDLE;
            x        <= 10'(PARK_X);
            obs_type <= '0;
            obs_pos  <= TOP;
            flick    <= 1'b0;
            fcnt     <= '0;
        end else if (retire) begin
            st    <= IDLE;
            x     <= 10'(PARK_X);
            flick <= 1'b0;
            fcnt  <= '0;
        end else if (tick && active) begin
            x <= x - {7'd0, speed};
            if (fcnt == FLICK_LAST) begin
                fcnt  <= '0;
                flick <= ~flick;
            end else begin
                fcnt <= fcnt + 1'b1;
            end
        end else if (spawn) begin
            st       <= ACTIVE;
            x        <= 10'(SPAWN_X);
            obs_type <= new_type;
            obs_pos  <= lane_fix(new_pos);
            flick    <= 1'b0;
            fcnt     <= '0;
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game FSM plus two obstacle slots: LFSR-driven spawns with a minimum gap, speed ramp, score.
// Latency: all outputs registered, updated on the frame_tick edge, visible the following cycle.
// Backpressure: none; frame_tick outside RUN is dropped, FROZEN holds everything until reset.
//
// Ports: clk, reset_n (async active-low); frame_tick, start, game_over (inputs);
//        obs1_*/obs2_* type/pos/x and flick1/flick2 per slot, running, score (outputs).
module obstacle_scheduler
    import jetpack_pkg::*;
#(
    parameter int          SPAWN_X        = 740,
    parameter int          PARK_X         = 1000,
    parameter int          MIN_GAP        = 320,
    parameter int          SPEED_INIT     = 2,
    parameter int          SPEED_MAX      = 7,
    parameter int          SPEEDUP_FRAMES = 600,
    parameter int          FLICK_FRAMES   = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       game_over,
    output logic [1:0] obs1_type,
    output logic [1:0] obs2_type,
    output logic [1:0] obs1_pos,
    output logic [1:0] obs2_pos,
    output logic [9:0] obs1_x,
    output logic [9:0] obs2_x,
    output logic       flick1,
    output logic       flick2,
    output logic       running,
    output logic [9:0] score
);

    localparam logic [9:0]  GAP_X       = 10'(SPAWN_X - MIN_GAP);
    localparam logic [2:0]  SPD_INIT    = 3'(SPEED_INIT);
    localparam logic [2:0]  SPD_MAX     = 3'(SPEED_MAX);
    localparam logic [15:0] FRAMES_LAST = 16'(SPEEDUP_FRAMES - 1);

    game_state_t state, state_nxt;
    logic [15:0] lfsr;
    logic [2:0]  speed;
    logic [15:0] frame_cnt;
    logic        upd;
    logic        spawn1, spawn2;
    logic        act1, act2;
    logic        ret1, ret2;
    logic [10:0] score_sum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT:    if (start)     state_nxt = RUN;
            RUN:     if (game_over) state_nxt = FROZEN;
            FROZEN:  state_nxt = FROZEN;
            default: state_nxt = WAIT;
        endcase
    end

    assign running = (state == RUN);
    // A collision on the tick edge wins: the field freezes without one last step.
    assign upd     = frame_tick && (state == RUN) && !game_over;

    // Spawn decisions look at pre-edge slot state; a slot retiring this tick is
    // still active here, so it cannot respawn until the next tick.
    assign spawn1 = upd && !act1 && (!act2 || (obs2_x <= GAP_X));
    assign spawn2 = upd && !act2 && !spawn1 && (!act1 || (obs1_x <= GAP_X));

    // x^16+x^14+x^13+x^11+1, free-running in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr <= LFSR_SEED;
        else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            speed     <= SPD_INIT;
            frame_cnt <= '0;
        end else if (upd) begin
            if (frame_cnt == FRAMES_LAST) begin
                frame_cnt <= '0;
                if (speed != SPD_MAX) speed <= speed + 3'd1;
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign score_sum = {1'b0, score} + {10'd0, ret1} + {10'd0, ret2};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                score <= '0;
        else if (score_sum > 11'd1023) score <= 10'd1023;
        else                         score <= score_sum[9:0];
    end

    obstacle_slot #(
        .SPAWN_X      (SPAWN_X),
        .PARK_X       (PARK_X),
        .FLICK_FRAMES (FLICK_FRAMES)
    ) u_slot1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (upd),
        .speed    (speed),
        .spawn    (spawn1),
        .new_type (lfsr[1:0]),
        .new_pos  (lfsr[3:2]),
        .x        (obs1_x),
        .obs_type (obs1_type),
        .obs_pos  (obs1_pos),
        .flick    (flick1),
        .active   (act1),
        .retire   (ret1)
    );

    obstacle_slot #(
        .SPAWN_X      (SPAWN_X),
        .PARK_X       (PARK_X),
        .FLICK_FRAMES (FLICK_FRAMES)
    ) u_slot2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (upd),
        .speed    (speed),
        .spawn    (spawn2),
        .new_type (lfsr[1:0]),
        .new_pos  (lfsr[3:2]),
        .x        (obs2_x),
        .obs_type (obs2_type),
        .obs_pos  (obs2_pos),
        .flick    (flick2),
        .active   (act2),
        .retire   (ret2)
    );

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: each frame tick pushes the reference model's
// expected outputs; a monitor pops and compares the cycle after every tick.
// Random tick spacing moves the LFSR phase, so spawn types and lanes vary between spawns.
`timescale 1ns/1ps
module tb_obstacle_scheduler;

    localparam int          SPAWN_X   = 740;
    localparam int          PARK_X    = 1000;
    localparam int          MIN_GAP   = 320;
    localparam int          SPEED_INI = 2;
    localparam int          SPEED_MAX = 7;
    localparam int          SPEEDUP   = 600;
    localparam int          FLICK     = 8;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       game_over = 1'b0;
    logic [1:0] obs1_type, obs2_type, obs1_pos, obs2_pos;
    logic [9:0] obs1_x, obs2_x, score;
    logic       flick1, flick2, running;

    always #5 clk = ~clk;

    obstacle_scheduler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .frame_tick (frame_tick),
        .start      (start),
        .game_over  (game_over),
        .obs1_type  (obs1_type),
        .obs2_type  (obs2_type),
        .obs1_pos   (obs1_pos),
        .obs2_pos   (obs2_pos),
        .obs1_x     (obs1_x),
        .obs2_x     (obs2_x),
        .flick1     (flick1),
        .flick2     (flick2),
        .running    (running),
        .score      (score)
    );

    typedef struct {
        int x1, x2, t1, t2, p1, p2, f1, f2, run, score, speed;
    } exp_t;

    exp_t expq[$];
    exp_t mon_e;
    int   checks;
    int   errors;

    // Reference model: game state 0=wait 1=run 2=frozen, slot arrays indexed 0/1.
    int m_state;
    int m_act[2], m_x[2], m_t[2], m_p[2], m_f[2], m_fc[2];
    int m_score, m_speed, m_frames;
    logic [15:0] b_lfsr;
    logic [15:0] last_lf;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) b_lfsr <= SEED;
        else          b_lfsr <= {b_lfsr[14:0], b_lfsr[15] ^ b_lfsr[13] ^ b_lfsr[12] ^ b_lfsr[10]};
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_x[i] = PARK_X; m_t[i] = 0; m_p[i] = 0; m_f[i] = 0; m_fc[i] = 0;
        end
        m_score  = 0;
        m_speed  = SPEED_INI;
        m_frames = 0;
    endtask

    task automatic model_tick(input logic go, input logic [15:0] lf);
        int xpre[2];
        int idle_pre[2];
        int ret[2];
        int sel;
        int raw;
        if (m_state != 1) return;
        if (go) begin
            m_state = 2;
            return;
        end
        for (int i = 0; i < 2; i++) begin
            xpre[i]     = m_x[i];
            idle_pre[i] = (m_act[i] == 0) ? 1 : 0;
            ret[i]      = (m_act[i] != 0 && m_x[i] < m_speed) ? 1 : 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (ret[i] != 0) begin
                m_act[i] = 0; m_x[i] = PARK_X; m_f[i] = 0; m_fc[i] = 0;
                if (m_score < 1023) m_score++;
            end else if (m_act[i] != 0) begin
                m_x[i] -= m_speed;
                m_fc[i]++;
                if (m_fc[i] == FLICK) begin
                    m_f[i]  = 1 - m_f[i];
                    m_fc[i] = 0;
                end
            end
        end
        sel = -1;
        if (idle_pre[0] != 0 && (idle_pre[1] != 0 || xpre[1] <= SPAWN_X - MIN_GAP))      sel = 0;
        else if (idle_pre[1] != 0 && (idle_pre[0] != 0 || xpre[0] <= SPAWN_X - MIN_GAP)) sel = 1;
        if (sel >= 0) begin
            raw         = int'(lf[3:2]);
            m_act[sel]  = 1;
            m_x[sel]    = SPAWN_X;
            m_t[sel]    = int'(lf[1:0]);
            m_p[sel]    = (raw == 3) ? 1 : raw;
            m_f[sel]    = 0;
            m_fc[sel]   = 0;
        end
        m_frames++;
        if (m_frames == SPEEDUP) begin
            m_frames = 0;
            if (m_speed < SPEED_MAX) m_speed++;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.x1 = m_x[0]; e.x2 = m_x[1];
        e.t1 = m_t[0]; e.t2 = m_t[1];
        e.p1 = m_p[0]; e.p2 = m_p[1];
        e.f1 = m_f[0]; e.f2 = m_f[1];
        e.run   = (m_state == 1) ? 1 : 0;
        e.score = m_score;
        e.speed = m_speed;
        expq.push_back(e);
    endtask

    task automatic do_tick(input logic go);
        @(negedge clk);
        last_lf = b_lfsr;
        model_tick(go, b_lfsr);
        push_exp();
        frame_tick = 1'b1;
        game_over  = go;
        @(negedge clk);
        frame_tick = 1'b0;
        game_over  = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x1"},      int'(obs1_x),    PARK_X);
        check({tag, "_x2"},      int'(obs2_x),    PARK_X);
        check({tag, "_type1"},   int'(obs1_type), 0);
        check({tag, "_type2"},   int'(obs2_type), 0);
        check({tag, "_pos1"},    int'(obs1_pos),  0);
        check({tag, "_pos2"},    int'(obs2_pos),  0);
        check({tag, "_flick1"},  int'(flick1),    0);
        check({tag, "_flick2"},  int'(flick2),    0);
        check({tag, "_running"}, int'(running),   0);
        check({tag, "_score"},   int'(score),     0);
        check({tag, "_speed"},   int'(dut.speed), SPEED_INI);
    endtask

    task automatic start_game();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        m_state = 1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    // Monitor: the DUT presents a fresh frame the cycle after every frame_tick.
    always @(posedge clk) begin
        if (frame_tick && reset_n) begin
            #1;
            if (expq.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                check("obs1_x",    int'(obs1_x),    mon_e.x1);
                check("obs2_x",    int'(obs2_x),    mon_e.x2);
                check("obs1_type", int'(obs1_type), mon_e.t1);
                check("obs2_type", int'(obs2_type), mon_e.t2);
                check("obs1_pos",  int'(obs1_pos),  mon_e.p1);
                check("obs2_pos",  int'(obs2_pos),  mon_e.p2);
                check("flick1",    int'(flick1),    mon_e.f1);
                check("flick2",    int'(flick2),    mon_e.f2);
                check("running",   int'(running),   mon_e.run);
                check("score",     int'(score),     mon_e.score);
                check("speed",     int'(dut.speed), mon_e.speed);
                check("lane_never_11", (obs1_pos != 2'b11 && obs2_pos != 2'b11) ? 1 : 0, 1);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        model_reset();

        reset_n = 1'b0;
        #12;
        check_reset_vals("reset");
        check("lane_fix_11", int'(jetpack_pkg::lane_fix(2'b11)), 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Ticks while waiting for start must be ignored.
        repeat ($urandom_range(2, 5)) do_tick(1'b0);
        start_game();

        for (int n = 1; n <= 4200; n++) begin
            do_tick(1'b0);
            case (n)
                1: begin
                    check("t1_obs1_x",    int'(obs1_x),    SPAWN_X);
                    check("t1_obs1_type", int'(obs1_type), int'(last_lf[1:0]));
                    check("t1_obs2_x",    int'(obs2_x),    PARK_X);
                    check("t1_running",   int'(running),   1);
                end
                161: begin
                    check("t161_obs1_x", int'(obs1_x), 420);
                    check("t161_obs2_x", int'(obs2_x), PARK_X);
                end
                162: check("t162_obs2_x", int'(obs2_x), SPAWN_X);
                371: check("t371_obs1_x", int'(obs1_x), 0);
                372: begin
                    check("t372_obs1_x", int'(obs1_x), PARK_X);
                    check("t372_score",  int'(score),  1);
                end
                599:  check("t599_speed",  int'(dut.speed), 2);
                600:  check("t600_speed",  int'(dut.speed), 3);
                3000: check("t3000_speed", int'(dut.speed), 7);
                4200: check("t4200_speed", int'(dut.speed), 7);
                default: ;
            endcase
        end

        // Collision on a tick edge: freeze with no final step, then hold for 100 ticks.
        do_tick(1'b1);
        check("frozen_running", int'(running), 0);
        repeat (100) do_tick(1'b0);
        check("frozen_running_after", int'(running), 0);

        // Second game, then an asynchronous reset in the middle of a cycle.
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_reset_vals("reset2");
        @(negedge clk);
        reset_n = 1'b1;
        start_game();
        repeat ($urandom_range(50, 400)) do_tick(1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_vals("reset_mid");
        model_reset();
        check("sb_drained", expq.size(), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Spawns, moves, retires and flickers the two on-screen obstacle slots that feed the frame renderer's `obs1_*` / `obs2_*` / `flick1` / `flick2` inputs. It runs one update per video frame on `frame_tick`. A 16-bit LFSR picks each obstacle's type and lane, and a minimum gap is enforced between the two slots. The block freezes the field on `game_over` and keeps the passed-obstacle score and the scroll speed.

## Interface
Parameters:
- `SPAWN_X`, 740: `obs_x` value written into a slot when it spawns.
- `PARK_X`, 1000: `obs_x` value held while a slot is idle.
- `MIN_GAP`, 320: a second spawn waits until the other slot's `x` ≤ `SPAWN_X - MIN_GAP`.
- `SPEED_INIT`, 2: scroll speed in px/frame after reset.
- `SPEED_MAX`, 7: saturation value for speed (3-bit).
- `SPEEDUP_FRAMES`, 600: number of RUN ticks per speed increment.
- `FLICK_FRAMES`, 8: number of ticks per flick toggle.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `frame_tick`, in, 1: one-cycle pulse, once per frame.
- `start`, in, 1: level input; leaves WAIT.
- `game_over`, in, 1: collision flag from the renderer.
- `obs1_type`, `obs2_type`, out, 2: obstacle shape.
- `obs1_pos`, `obs2_pos`, out, 2: lane (00 top, 01 middle, 10 bottom; 11 is never driven).
- `obs1_x`, `obs2_x`, out, 10: slot x position.
- `flick1`, `flick2`, out, 1: colour flicker per slot.
- `running`, out, 1: high while the game state is RUN.
- `score`, out, 10: retired obstacles, saturating at 1023.

## Operation
- Game FSM states are WAIT, RUN and FROZEN. Reset enters WAIT.
  - WAIT→RUN on `start`.
  - RUN→FROZEN on `game_over`.
  - FROZEN is terminal; only reset leaves it.
- A frame update occurs only on a clock edge where `frame_tick`=1 and the state is RUN.
  - If `game_over`=1 on the same edge, the state goes to FROZEN and no update is applied.
- Each slot is either IDLE or ACTIVE. At each frame update, using the pre-edge registered values:
  - ACTIVE with `x < speed`: the slot goes IDLE, `x`←`PARK_X`, `flick`←0, and `score`+1 (saturating). If both slots retire on the same tick, `score` increases by 2.
  - ACTIVE otherwise: `x`←`x - speed`. The `flick` counter increments; when it reaches `FLICK_FRAMES`, `flick` toggles and the counter clears.
  - A slot that retires on a tick cannot spawn on that same tick.
- Spawn rule, at most one spawn per tick:
  - A slot that was IDLE before the edge spawns if the other slot is IDLE or the other slot's `x` ≤ `SPAWN_X - MIN_GAP`.
  - Slot 1 wins if both slots qualify.
  - On spawn: `x`←`SPAWN_X`, `type`←`lfsr[1:0]`, `pos`←`lfsr[3:2]` with 11 mapped to 01, and the flick counter and `flick` clear.
  - A spawned slot first moves on the next tick.
- Speed: a frame counter counts RUN ticks. On reaching `SPEEDUP_FRAMES` it clears, and speed increments until it saturates at `SPEED_MAX`.
- LFSR: Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - It shifts left on every clock in every state, with feedback into bit 0.
  - It is never all-zero.
- FROZEN holds every output constant.

## Timing
- All outputs are registered and change only on the update edge.
  - New values are visible in the cycle after `frame_tick`.
  - The renderer's 1-cycle ROM latency is therefore absorbed well before active video.
- Reset values:
  - state WAIT, `running`=0.
  - `obs*_x`=`PARK_X`, `obs*_type`=0, `obs*_pos`=0, `flick*`=0, slots IDLE.
  - `score`=0, speed=`SPEED_INIT`, frame counter 0, LFSR=`LFSR_SEED`.
- Asserting `reset_n` low mid-frame clears everything immediately (asynchronous). Release is synchronised by the system reset bridge.
- The `start` edge and the first tick are independent. The first spawn happens on the first tick after entering RUN.
- `frame_tick` arriving in WAIT or FROZEN is ignored.

## Structure
- Package `jetpack_pkg` holds:
  - `game_state_t` {WAIT, RUN, FROZEN} and `slot_state_t` {IDLE, ACTIVE}.
  - `obs_type_t` and `obs_pos_t` (2-bit), plus the lane constants TOP=0, MID=1, BOT=2.
  - A `lane_fix` function mapping 11→01.
- Sub-module `obstacle_slot`, instantiated twice, contains:
  - inputs: `tick`, `speed`, `spawn`, `new_type`, `new_pos`.
  - outputs: `x`, `type`, `pos`, `flick`, `active`, `retire` pulse.
  - the slot's own state register and flick counter.
- The top level holds the game FSM, LFSR, spawn arbitration, speed and frame counter, and score.

## Test plan
- Reset, then `start`, then tick 1 → `obs1_x`=740, `obs1_type`=LFSR[1:0] at that edge, `obs2_x`=1000, `running`=1.
- Default parameters, ticks continue:
  - After tick 161, `obs1_x`=420 and slot 2 is still idle.
  - On tick 162, `obs2_x`=740.
- Tick 371 → `obs1_x`=0. Tick 372 → slot 1 retires, `obs1_x`=1000, `score`=1.
- Force LFSR[3:2]=11 at a spawn → `pos`=01. Across 1000 spawns, `pos` never equals 11.
- `game_over`=1 together with `frame_tick` → no position change, and all outputs are constant for 100 further ticks.
- 600 RUN ticks → speed 3. After 3000 ticks speed is 7, and it stays 7 at 4200 ticks.
- Assert `reset_n`=0 mid-frame during RUN → all outputs return to their reset values within the same cycle.
